// File: rtl/combat_resolver_pkg.sv
// Shared types and constants for the fighter combat resolver.
package combat_pkg;

   localparam int unsigned HEALTH_W = 7;
   localparam int unsigned POS_W    = 10;
   localparam int unsigned CNT_W    = 5;

   localparam logic [1:0] BACK_NONE  = 2'd0;
   localparam logic [1:0] BACK_GUARD = 2'd1;
   localparam logic [1:0] BACK_STUN  = 2'd2;

   typedef enum logic [1:0] {IDLE, STUN, GUARD} hit_state_t;

   // Edge-detect history kept only for the flags that start attacks
   typedef struct packed {
      logic kick;
      logic fight;
   } attack_t;

   function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/combat_resolver_if.sv
// Player positions/actions in, knockback/health/win state out.
interface combat_resolver_if;

   logic [combat_pkg::POS_W-1:0]    BallX1, BallY1, BallX2, BallY2;
   logic                            kick1, fight1, dodge1, jump1;
   logic                            kick2, fight2, dodge2, jump2;
   logic [1:0]                      back1, back2;
   logic [combat_pkg::HEALTH_W-1:0] health1, health2;
   logic                            p1win, p2win;

   modport master (
      output BallX1, BallY1, BallX2, BallY2,
      output kick1, fight1, dodge1, jump1,
      output kick2, fight2, dodge2, jump2,
      input  back1, back2, health1, health2, p1win, p2win
   );

   modport slave (
      input  BallX1, BallY1, BallX2, BallY2,
      input  kick1, fight1, dodge1, jump1,
      input  kick2, fight2, dodge2, jump2,
      output back1, back2, health1, health2, p1win, p2win
   );

endinterface

// File: rtl/combat_resolver_defender_fsm.sv
// One defender: hit/guard state, frame counter, saturating health, back code.
module defender_fsm
   import combat_pkg::*;
#(
   parameter int unsigned KICK_DMG     = 10,
   parameter int unsigned FIGHT_DMG    = 5,
   parameter int unsigned STUN_FRAMES  = 12,
   parameter int unsigned GUARD_FRAMES = 6,
   parameter int unsigned HEALTH_INIT  = 100
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick_i,
   input  logic                attack_kick_i,
   input  logic                attack_fight_i,
   input  logic                contact_i,
   input  logic                guard_i,
   input  logic                freeze_i,
   output logic [1:0]          back_o,
   output logic [HEALTH_W-1:0] health_o,
   output logic [HEALTH_W-1:0] health_nxt_c
);

   hit_state_t          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          back_q, back_d;
   logic [HEALTH_W-1:0] health_q, health_d;
   logic [HEALTH_W-1:0] dmg;
   logic [HEALTH_W-1:0] hit_health;

   // Simultaneous kick and punch resolve as the heavier kick
   assign dmg        = attack_kick_i ? HEALTH_W'(KICK_DMG) : HEALTH_W'(FIGHT_DMG);
   assign hit_health = (health_q > dmg) ? (health_q - dmg) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         back_q   <= BACK_NONE;
         health_q <= HEALTH_W'(HEALTH_INIT);
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         back_q   <= back_d;
         health_q <= health_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      back_d   = back_q;
      health_d = health_q;
      if (freeze_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         back_d  = BACK_NONE;
      end else if (tick_i) begin
         unique case (state_q)
            IDLE: begin
               if ((attack_kick_i || attack_fight_i) && contact_i) begin
                  cnt_d = '0;
                  if (guard_i) begin
                     state_d = GUARD;
                     back_d  = BACK_GUARD;
                  end else begin
                     health_d = hit_health;
                     // A knockout ends the bout, so no stun is started
                     if (hit_health != '0) begin
                        state_d = STUN;
                        back_d  = BACK_STUN;
                     end
                  end
               end
            end
            STUN: begin
               if (cnt_q == CNT_W'(STUN_FRAMES - 1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  back_d  = BACK_NONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            GUARD: begin
               if (cnt_q == CNT_W'(GUARD_FRAMES - 1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  back_d  = BACK_NONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               back_d  = BACK_NONE;
            end
         endcase
      end
   end

   assign back_o       = back_q;
   assign health_o     = health_q;
   assign health_nxt_c = health_d;

endmodule

// File: rtl/combat_resolver.sv
// Frame-synchronous attack resolution between two fighters with win latch.
module combat_resolver
   import combat_pkg::*;
#(
   parameter int unsigned HIT_RANGE_X  = 50,
   parameter int unsigned HIT_RANGE_Y  = 50,
   parameter int unsigned KICK_DMG     = 10,
   parameter int unsigned FIGHT_DMG    = 5,
   parameter int unsigned STUN_FRAMES  = 12,
   parameter int unsigned GUARD_FRAMES = 6,
   parameter int unsigned HEALTH_INIT  = 100
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_clk,
   combat_resolver_if.slave  bus
);

   logic [2:0]          fsync_q;
   logic                tick_q;
   attack_t             act1, act2, prev1_q, prev2_q;
   logic                atk1_kick, atk1_fight, atk2_kick, atk2_fight;
   logic [POS_W-1:0]    dx, dy;
   logic                contact;
   logic [HEALTH_W-1:0] health1_nxt, health2_nxt;
   logic                p1win_q, p1win_d, p2win_q, p2win_d;
   logic                win_any;

   // Two-stage synchronizer, third stage feeds the registered edge detect
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         fsync_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         fsync_q <= {fsync_q[1:0], frame_clk};
         tick_q  <= fsync_q[1] & ~fsync_q[2];
      end
   end

   assign act1 = '{kick: bus.kick1, fight: bus.fight1};
   assign act2 = '{kick: bus.kick2, fight: bus.fight2};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         prev1_q <= '0;
         prev2_q <= '0;
      end else if (tick_q) begin
         prev1_q <= act1;
         prev2_q <= act2;
      end
   end

   assign atk1_kick  = act1.kick  & ~prev1_q.kick;
   assign atk1_fight = act1.fight & ~prev1_q.fight;
   assign atk2_kick  = act2.kick  & ~prev2_q.kick;
   assign atk2_fight = act2.fight & ~prev2_q.fight;

   assign dx      = abs_diff(bus.BallX1, bus.BallX2);
   assign dy      = abs_diff(bus.BallY1, bus.BallY2);
   assign contact = (dx <= POS_W'(HIT_RANGE_X)) && (dy <= POS_W'(HIT_RANGE_Y));
   assign win_any = p1win_q | p2win_q;

   defender_fsm #(
      .KICK_DMG(KICK_DMG), .FIGHT_DMG(FIGHT_DMG), .STUN_FRAMES(STUN_FRAMES),
      .GUARD_FRAMES(GUARD_FRAMES), .HEALTH_INIT(HEALTH_INIT)
   ) u_def1 (
      .clk(Clk), .rst_n(Reset), .tick_i(tick_q),
      .attack_kick_i(atk2_kick), .attack_fight_i(atk2_fight),
      .contact_i(contact), .guard_i(bus.dodge1 | bus.jump1), .freeze_i(win_any),
      .back_o(bus.back1), .health_o(bus.health1), .health_nxt_c(health1_nxt)
   );

   defender_fsm #(
      .KICK_DMG(KICK_DMG), .FIGHT_DMG(FIGHT_DMG), .STUN_FRAMES(STUN_FRAMES),
      .GUARD_FRAMES(GUARD_FRAMES), .HEALTH_INIT(HEALTH_INIT)
   ) u_def2 (
      .clk(Clk), .rst_n(Reset), .tick_i(tick_q),
      .attack_kick_i(atk1_kick), .attack_fight_i(atk1_fight),
      .contact_i(contact), .guard_i(bus.dodge2 | bus.jump2), .freeze_i(win_any),
      .back_o(bus.back2), .health_o(bus.health2), .health_nxt_c(health2_nxt)
   );

   // Win flags set on the same edge as the health update that reaches zero
   always_comb begin
      p1win_d = p1win_q;
      p2win_d = p2win_q;
      if (!win_any) begin
         if (health2_nxt == '0) p1win_d = 1'b1;
         if (health1_nxt == '0) p2win_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         p1win_q <= 1'b0;
         p2win_q <= 1'b0;
      end else begin
         p1win_q <= p1win_d;
         p2win_q <= p2win_d;
      end
   end

   assign bus.p1win = p1win_q;
   assign bus.p2win = p2win_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver with hand-computed expectations.
module tb_combat_resolver;

   logic clk;
   logic rst_n;
   logic frame_clk;
   int   checks;
   int   errors;

   combat_resolver_if bus ();

   combat_resolver dut (
      .Clk       (clk),
      .Reset     (rst_n),
      .frame_clk (frame_clk),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One frame strobe; returns one Clk cycle after the resulting tick edge
   task automatic frame_tick();
      repeat (3) @(negedge clk);
      frame_clk = 1'b1;
      repeat (4) @(negedge clk);
      frame_clk = 1'b0;
   endtask

   // Player-1 attack on player 2, then let any stun run out
   task automatic hit(input logic k, input logic f, input int exp_h2, input int exp_b2);
      bus.kick1  = k;
      bus.fight1 = f;
      frame_tick();
      check("hit_health2", bus.health2, exp_h2);
      check("hit_back2", bus.back2, exp_b2);
      bus.kick1  = 1'b0;
      bus.fight1 = 1'b0;
      repeat (12) frame_tick();
      check("hit_recover_back2", bus.back2, 0);
   endtask

   initial begin
      int kick_exp [6];
      kick_exp = '{60, 50, 40, 30, 20, 10};
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      frame_clk = 1'b0;
      {bus.kick1, bus.fight1, bus.dodge1, bus.jump1} = '0;
      {bus.kick2, bus.fight2, bus.dodge2, bus.jump2} = '0;
      bus.BallX1 = 10'd300; bus.BallY1 = 10'd300;
      bus.BallX2 = 10'd340; bus.BallY2 = 10'd300;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle with no frame activity
      repeat (1000) @(negedge clk);
      check("rst_back1", bus.back1, 0);
      check("rst_back2", bus.back2, 0);
      check("rst_health1", bus.health1, 100);
      check("rst_health2", bus.health2, 100);
      check("rst_p1win", bus.p1win, 0);
      check("rst_p2win", bus.p2win, 0);

      // Kick at dx=40 lands, stun holds 12 ticks
      frame_tick();
      bus.kick1 = 1'b1;
      frame_tick();
      check("kick_health2", bus.health2, 90);
      check("kick_back2", bus.back2, 2);
      check("kick_health1", bus.health1, 100);
      check("kick_back1", bus.back1, 0);
      bus.kick1 = 1'b0;
      for (int i = 1; i < 12; i++) begin
         frame_tick();
         check("stun_hold", bus.back2, 2);
      end
      frame_tick();
      check("stun_end", bus.back2, 0);
      check("stun_end_health2", bus.health2, 90);

      // Punch into a dodge is guarded for 6 ticks
      bus.fight1 = 1'b1;
      bus.dodge2 = 1'b1;
      frame_tick();
      check("guard_back2", bus.back2, 1);
      check("guard_health2", bus.health2, 90);
      bus.fight1 = 1'b0;
      for (int i = 1; i < 6; i++) begin
         frame_tick();
         check("guard_hold", bus.back2, 1);
      end
      frame_tick();
      check("guard_end", bus.back2, 0);
      bus.dodge2 = 1'b0;

      // dx=51 misses, dy=51 misses, dx=50 hits
      bus.BallX2 = 10'd351;
      bus.kick1  = 1'b1;
      frame_tick();
      check("miss_x_back2", bus.back2, 0);
      check("miss_x_health2", bus.health2, 90);
      bus.kick1 = 1'b0;
      frame_tick();
      bus.BallX2 = 10'd300;
      bus.BallY2 = 10'd249;
      bus.kick1  = 1'b1;
      frame_tick();
      check("miss_y_health2", bus.health2, 90);
      bus.kick1 = 1'b0;
      frame_tick();
      bus.BallY2 = 10'd300;
      bus.BallX2 = 10'd350;
      hit(1'b1, 1'b0, 80, 2);

      // Mutual attack; kick+fight together counts as a kick
      bus.kick1  = 1'b1;
      bus.fight1 = 1'b1;
      bus.fight2 = 1'b1;
      frame_tick();
      check("mutual_health2", bus.health2, 70);
      check("mutual_health1", bus.health1, 95);
      check("mutual_back1", bus.back1, 2);
      check("mutual_back2", bus.back2, 2);
      {bus.kick1, bus.fight1, bus.fight2} = '0;
      repeat (12) frame_tick();
      check("mutual_end_back1", bus.back1, 0);
      check("mutual_end_back2", bus.back2, 0);

      // A kick pulse entirely between ticks is not seen
      bus.kick1 = 1'b1;
      @(negedge clk);
      bus.kick1 = 1'b0;
      frame_tick();
      check("pulse_health2", bus.health2, 70);
      check("pulse_back2", bus.back2, 0);

      // Player-2 kick into a jump is guarded
      bus.kick2 = 1'b1;
      bus.jump1 = 1'b1;
      frame_tick();
      check("jump_back1", bus.back1, 1);
      check("jump_health1", bus.health1, 95);
      bus.kick2 = 1'b0;
      bus.jump1 = 1'b0;
      repeat (6) frame_tick();
      check("jump_end_back1", bus.back1, 0);

      // Wear player 2 down to 5, then the finishing punch
      foreach (kick_exp[i]) hit(1'b1, 1'b0, kick_exp[i], 2);
      hit(1'b0, 1'b1, 5, 2);
      bus.fight1 = 1'b1;
      frame_tick();
      check("ko_health2", bus.health2, 0);
      check("ko_p1win", bus.p1win, 1);
      check("ko_p2win", bus.p2win, 0);
      check("ko_back2", bus.back2, 0);
      bus.fight1 = 1'b0;
      frame_tick();
      bus.kick1 = 1'b1;
      bus.kick2 = 1'b1;
      frame_tick();
      check("frozen_health2", bus.health2, 0);
      check("frozen_back2", bus.back2, 0);
      check("frozen_health1", bus.health1, 95);
      check("frozen_back1", bus.back1, 0);
      check("frozen_p1win", bus.p1win, 1);
      bus.kick1 = 1'b0;
      bus.kick2 = 1'b0;

      // Asynchronous reset in the middle of a stun
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      frame_tick();
      bus.kick1 = 1'b1;
      frame_tick();
      check("pre_rst_health2", bus.health2, 90);
      check("pre_rst_back2", bus.back2, 2);
      frame_tick();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_back2", bus.back2, 0);
      check("async_rst_health2", bus.health2, 100);
      check("async_rst_p1win", bus.p1win, 0);
      bus.kick1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      frame_tick();
      check("post_rst_health2", bus.health2, 100);
      check("post_rst_back2", bus.back2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
